// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default oversampling constants.
// UART_TX_PARITY_EN widens the state type to make room for ST_PARITY.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_PARITY = 3'd4
    } uart_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;
`endif

    localparam int N_TICK_DEF  = 16;
    localparam int SB_TICK_DEF = 16;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: LSB-first start/data/stop framing driven by a 16x baud tick.
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module uart_tx
    import uart_pkg::*;
#(
    parameter int NB_BITS     = 8,
    parameter int N_TICK      = N_TICK_DEF,
    parameter int SB_TICK     = SB_TICK_DEF,
    parameter int NB_TICK_CNT = 5,
    parameter int NB_BIT_CNT  = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_tx_start,
    input  logic [NB_BITS-1:0] i_data,
    output logic               o_tx,
    output logic               o_tx_done,
    output logic               o_busy
);

    localparam logic [NB_TICK_CNT-1:0] TICK_LAST = NB_TICK_CNT'(N_TICK - 1);
    localparam logic [NB_TICK_CNT-1:0] STOP_LAST = NB_TICK_CNT'(SB_TICK - 1);
    localparam logic [NB_BIT_CNT-1:0]  BIT_LAST  = NB_BIT_CNT'(NB_BITS - 1);

    uart_state_t              r_state,      w_state_next;
    logic [NB_TICK_CNT-1:0]   r_tick_cnt,   w_tick_cnt_next;
    logic [NB_BIT_CNT-1:0]    r_bit_idx,    w_bit_idx_next;
    logic [NB_BITS-1:0]       r_shreg,      w_shreg_next;
    logic                     r_start_prev;
    logic                     r_tx,         w_tx_next;
    logic                     r_tx_done,    w_tx_done_next;
    logic                     r_busy;
    logic                     w_edge;
`ifdef UART_TX_PARITY_EN
    logic                     r_parity,     w_parity_next;
`endif

    assign w_edge = i_tx_start && !r_start_prev;

    always_comb begin
        w_state_next    = r_state;
        w_tick_cnt_next = r_tick_cnt;
        w_bit_idx_next  = r_bit_idx;
        w_shreg_next    = r_shreg;
        w_tx_done_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_next   = r_parity;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (w_edge) begin
                    w_state_next    = ST_START;
                    w_shreg_next    = i_data;
                    w_tick_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                    w_parity_next   = ^i_data;
`endif
                end
            end
            ST_START: begin
                if (i_tick) begin
                    if (r_tick_cnt == TICK_LAST) begin
                        w_state_next    = ST_DATA;
                        w_tick_cnt_next = '0;
                        w_bit_idx_next  = '0;
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + NB_TICK_CNT'(1);
                    end
                end
            end
            ST_DATA: begin
                if (i_tick) begin
                    if (r_tick_cnt == TICK_LAST) begin
                        w_shreg_next    = r_shreg >> 1;
                        w_tick_cnt_next = '0;
                        if (r_bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            w_state_next = ST_PARITY;
`else
                            w_state_next = ST_STOP;
`endif
                        end else begin
                            w_bit_idx_next = r_bit_idx + NB_BIT_CNT'(1);
                        end
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + NB_TICK_CNT'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (i_tick) begin
                    if (r_tick_cnt == TICK_LAST) begin
                        w_state_next    = ST_STOP;
                        w_tick_cnt_next = '0;
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + NB_TICK_CNT'(1);
                    end
                end
            end
`endif
            ST_STOP: begin
                if (i_tick) begin
                    if (r_tick_cnt == STOP_LAST) begin
                        w_state_next    = ST_IDLE;
                        w_tick_cnt_next = '0;
                        w_tx_done_next  = 1'b1;
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + NB_TICK_CNT'(1);
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        // NOTE: the line level is derived from the next state so the registered o_tx
        // changes on the same edge the state does, with no glitchy combinational output.
        unique case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shreg_next[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_tx_next = w_parity_next;
`endif
            default:   w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_tick_cnt   <= '0;
            r_bit_idx    <= '0;
            r_shreg      <= '0;
            r_start_prev <= 1'b0;
            r_tx         <= 1'b1;
            r_tx_done    <= 1'b0;
            r_busy       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_tick_cnt   <= w_tick_cnt_next;
            r_bit_idx    <= w_bit_idx_next;
            r_shreg      <= w_shreg_next;
            r_start_prev <= i_tx_start;
            r_tx         <= w_tx_next;
            r_tx_done    <= w_tx_done_next;
            r_busy       <= (w_state_next != ST_IDLE);
`ifdef UART_TX_PARITY_EN
            r_parity     <= w_parity_next;
`endif
        end
    end

    assign o_tx      = r_tx;
    assign o_tx_done = r_tx_done;
    assign o_busy    = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: frames are decoded from o_tx at mid-bit and
// compared against bytes queued when each start edge is driven.
module tb_uart_tx;

    localparam int NB_BITS   = 8;
    localparam int TICK_DIV  = 4;
    localparam int BIT_CLKS  = 16 * TICK_DIV;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = NB_BITS + 3;
`else
    localparam int FRAME_BITS = NB_BITS + 2;
`endif
    localparam int FRAME_CLKS = FRAME_BITS * BIT_CLKS;

    logic               clk;
    logic               i_rst;
    logic               i_tick;
    logic               i_tx_start;
    logic [NB_BITS-1:0] i_data;
    logic               o_tx;
    logic               o_tx_done;
    logic               o_busy;

    int                 n_total;
    int                 n_bad;
    int                 cyc;
    int                 e_cyc;
    int                 done_cnt;
    int                 tx_low_cnt;
    logic [NB_BITS-1:0] exp_q[$];

    uart_tx dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_tick     (i_tick),
        .i_tx_start (i_tx_start),
        .i_data     (i_data),
        .o_tx       (o_tx),
        .o_tx_done  (o_tx_done),
        .o_busy     (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud tick every TICK_DIV clocks, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc    = cyc + 1;
        i_tick = ((cyc % TICK_DIV) == 0);
    end

    always @(negedge clk) begin
        if (o_tx_done === 1'b1) done_cnt = done_cnt + 1;
        if (o_tx === 1'b0)      tx_low_cnt = tx_low_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    // Raise i_tx_start so the accepted edge coincides with a baud tick.
    task automatic send_start(input logic [NB_BITS-1:0] d, input bit push);
        for (int i = 0; i < 2 * TICK_DIV; i++) begin
            @(posedge clk); #2;
            if (i_tick) break;
        end
        i_tx_start = 1'b1;
        i_data     = d;
        @(posedge clk); #2;
        e_cyc = cyc;
        if (push) exp_q.push_back(d);
    endtask

    task automatic recv_frame(input bit chk_timing);
        logic [NB_BITS-1:0] rx;
        logic [NB_BITS-1:0] exp_b;
        logic               start_b, stop_b, par_b;
        bit                 busy_ok, seen;
        int                 done_at;
        rx = '0; par_b = 1'b0; busy_ok = 1'b1; seen = 1'b0; done_at = 0;
        repeat (BIT_CLKS / 2) @(posedge clk);
        @(negedge clk);
        start_b = o_tx;
        busy_ok = busy_ok && (o_busy === 1'b1);
        for (int k = 0; k < NB_BITS; k++) begin
            repeat (BIT_CLKS) @(negedge clk);
            rx[k]   = o_tx;
            busy_ok = busy_ok && (o_busy === 1'b1);
        end
`ifdef UART_TX_PARITY_EN
        repeat (BIT_CLKS) @(negedge clk);
        par_b   = o_tx;
        busy_ok = busy_ok && (o_busy === 1'b1);
`endif
        repeat (BIT_CLKS) @(negedge clk);
        stop_b  = o_tx;
        busy_ok = busy_ok && (o_busy === 1'b1);
        for (int i = 0; i < 100; i++) begin
            if (o_tx_done === 1'b1) begin seen = 1'b1; done_at = cyc; break; end
            @(negedge clk);
        end

        n_total++; if (start_b !== 1'b0) begin n_bad++; $display("FAIL start_bit: got %b want 0", start_b); end
        n_total++; if (stop_b !== 1'b1) begin n_bad++; $display("FAIL stop_bit: got %b want 1", stop_b); end
        n_total++; if (!busy_ok) begin n_bad++; $display("FAIL busy_in_frame: o_busy dropped during frame"); end
        n_total++; if (!seen) begin n_bad++; $display("FAIL done_seen: no o_tx_done within 100 clks of stop bit"); end
        if (seen) begin
            if (chk_timing) begin
                n_total++;
                if (done_at - e_cyc != FRAME_CLKS) begin
                    n_bad++; $display("FAIL done_latency: got %0d clks want %0d", done_at - e_cyc, FRAME_CLKS);
                end
            end
            n_total++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL busy_at_done: got %b want 0", o_busy); end
            @(negedge clk);
            n_total++; if (o_tx_done !== 1'b0) begin n_bad++; $display("FAIL done_width: pulse longer than 1 clk"); end
        end
        n_total++;
        if (exp_q.size() == 0) begin
            n_bad++; $display("FAIL scoreboard_empty: got frame %h with nothing expected", rx);
        end else begin
            exp_b = exp_q.pop_front();
            if (rx !== exp_b) begin n_bad++; $display("FAIL frame_data: got %h want %h", rx, exp_b); end
`ifdef UART_TX_PARITY_EN
            n_total++;
            if (par_b !== ^exp_b) begin n_bad++; $display("FAIL parity_bit: got %b want %b", par_b, ^exp_b); end
`endif
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_tx_start = 1'b0; i_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++; if (o_tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", o_tx); end
        n_total++; if (o_tx_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", o_tx_done); end
        n_total++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        #2; i_rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_total++; if (o_tx !== 1'b1) begin n_bad++; $display("FAIL idle_tx: got %b want 1", o_tx); end
    endtask

    task automatic test_frame();
        int d0;
        d0 = done_cnt;
        send_start(8'h35, 1'b1);
        recv_frame(1'b1);
        @(posedge clk); #2; i_tx_start = 1'b0;
        n_total++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL frame_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_held_start();
        int d0, l0;
        d0 = done_cnt;
        send_start(8'h0A, 1'b1);
        recv_frame(1'b1);
        repeat (3) @(posedge clk);
        #2; i_tx_start = 1'b0;
        l0 = tx_low_cnt;
        repeat (200) @(posedge clk);
        @(negedge clk);
        n_total++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL held_done_count: got %0d want 1", done_cnt - d0); end
        n_total++; if (tx_low_cnt != l0) begin n_bad++; $display("FAIL held_restart: tx low for %0d clks want 0", tx_low_cnt - l0); end
        n_total++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL held_busy: got %b want 0", o_busy); end
    endtask

    task automatic test_busy_ignore();
        int d0, l0;
        d0 = done_cnt;
        send_start(8'h03, 1'b1);
        fork
            recv_frame(1'b1);
            begin
                repeat (10) @(posedge clk);
                #2; i_tx_start = 1'b0;
                repeat (3 * BIT_CLKS + BIT_CLKS / 2 - 10) @(posedge clk);
                #2; i_tx_start = 1'b1; i_data = 8'hFF;
            end
        join
        @(posedge clk); #2; i_tx_start = 1'b0;
        l0 = tx_low_cnt;
        repeat (FRAME_CLKS + 50) @(posedge clk);
        @(negedge clk);
        n_total++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL busy_done_count: got %0d want 1", done_cnt - d0); end
        n_total++; if (tx_low_cnt != l0) begin n_bad++; $display("FAIL busy_queued: tx low for %0d clks want 0", tx_low_cnt - l0); end
    endtask

    task automatic test_reset_mid_frame();
        int d0;
        send_start(8'h52, 1'b0);
        repeat (10) @(posedge clk);
        #2; i_tx_start = 1'b0;
        repeat (4 * BIT_CLKS + BIT_CLKS / 2 - 10) @(posedge clk);
        @(negedge clk);
        n_total++; if (o_tx !== 1'b0) begin n_bad++; $display("FAIL mid_bit3: got %b want 0", o_tx); end
        d0 = done_cnt;
        @(posedge clk); #2; i_rst = 1'b1;
        @(posedge clk); #2; i_rst = 1'b0;
        @(negedge clk);
        n_total++; if (o_tx !== 1'b1) begin n_bad++; $display("FAIL rst_mid_tx: got %b want 1", o_tx); end
        n_total++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", o_busy); end
        repeat (FRAME_CLKS) @(posedge clk);
        @(negedge clk);
        n_total++; if (done_cnt != d0) begin n_bad++; $display("FAIL rst_mid_done: got %0d pulses want 0", done_cnt - d0); end
        send_start(8'hC3, 1'b1);
        recv_frame(1'b1);
        @(posedge clk); #2; i_tx_start = 1'b0;
    endtask

    task automatic test_start_at_reset();
        @(posedge clk); #2;
        i_rst = 1'b1; i_tx_start = 1'b1; i_data = 8'h81;
        repeat (2) @(posedge clk);
        #2; i_rst = 1'b0;
        @(posedge clk); #2;
        e_cyc = cyc;
        exp_q.push_back(8'h81);
        recv_frame(1'b0);
        @(posedge clk); #2; i_tx_start = 1'b0;
    endtask

    // Mimics the calculator interface: start is released once o_tx_done is seen,
    // and the next result is offered as soon as the line is idle.
    task automatic test_back_to_back();
        send_start(8'h37, 1'b1);
        fork
            recv_frame(1'b1);
            begin
                for (int i = 0; i < FRAME_CLKS + 100; i++) begin
                    @(negedge clk);
                    if (o_tx_done === 1'b1) break;
                end
                @(posedge clk); #2; i_tx_start = 1'b0;
            end
        join
        send_start(8'h41, 1'b1);
        recv_frame(1'b1);
        @(posedge clk); #2; i_tx_start = 1'b0;
    endtask

    initial begin
        n_total = 0; n_bad = 0; cyc = 0; e_cyc = 0;
        done_cnt = 0; tx_low_cnt = 0;
        i_tick = 1'b0; i_rst = 1'b1; i_tx_start = 1'b0; i_data = '0;
        test_reset();
        test_frame();
        test_held_start();
        test_busy_ignore();
        test_reset_mid_frame();
        test_start_at_reset();
        test_back_to_back();
        n_total++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL scoreboard_leftover: %0d frames never seen", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
